adc_volt_meas: RTL
==================

# adc_volt_meas

ADC front-end and voltage-computation stage for the digital voltmeter. It drives the 8-bit parallel ADC sample clock, captures `ad_data`, and self-calibrates the zero point from the first samples after reset. It then block-averages samples and converts the result to a signed millivolt magnitude. Its `volt`/`sign` outputs feed the dynamic 7-segment/595 display driver directly, with `volt` zero-extended to that driver's data width.

## Interface
- `CAL_SHIFT`, 10: calibration window = 2^CAL_SHIFT samples.
- `AVG_SHIFT`, 3: averaging block = 2^AVG_SHIFT samples.
- `FS_MV`, 10000: full-scale magnitude in mV (ADC code 255 or 0 at the respective rail).
- `sys_clk` input 1: system clock, 50 MHz.
- `sys_rst` input 1: asynchronous, active-high reset.
- `ad_data` input 8: ADC output code, valid while `ad_clk` is high.
- `ad_clk` output 1: ADC sample clock, sys_clk/2.
- `volt` output 16: unsigned magnitude in mV.
- `sign` output 1: 1 = negative.
- `volt_vld` output 1: one-cycle pulse when `volt`/`sign` update.
- `cal_done` output 1: high once calibration and step computation have finished.

## Operation
- `ad_clk` toggles every `sys_clk` cycle.
- A sample is captured on each `sys_clk` edge where registered `ad_clk` = 1, giving one sample per 2 cycles.
- FSM states are CAL → DIV_P → DIV_N → RUN. There is no other exit; only reset returns the FSM to CAL.
- **CAL**
  - Accumulate 2^CAL_SHIFT samples into an 18-bit sum.
  - `mid` = sum >> CAL_SHIFT (8 bits).
  - Go to DIV_P on the cycle after the last sample.
- **DIV_P**
  - Sequential restoring divider, 1 quotient bit per cycle, 27-bit numerator N = FS_MV << 13.
  - Compute `step_p` = N / (255 − mid).
  - If the divisor is 0, force `step_p` = 0 and skip directly to the next state.
- **DIV_N**
  - Same divider, computing `step_n` = N / mid.
  - If `mid` = 0, force `step_n` = 0.
  - On completion, assert `cal_done` and go to RUN.
- **Sample handling outside RUN:** samples arriving in DIV_P/DIV_N are discarded. The averaging block starts with the first sample captured in RUN.
- **RUN**
  - Accumulate 2^AVG_SHIFT samples (11-bit sum); `avg` = sum >> AVG_SHIFT.
  - If `avg` ≥ `mid`: `diff` = avg − mid, step = `step_p`, `sign` = 0.
  - Otherwise: `diff` = mid − avg, step = `step_n`, `sign` = 1.
  - `volt` = (diff × step) >> 13, using a 35-bit product and truncation. The result is clamped to FS_MV.
  - If the computed `volt` = 0, `sign` is forced to 0.
- **Reset values:** `ad_clk`, `volt`, `sign`, `volt_vld`, `cal_done` are 0. `mid`, `step_p`, `step_n`, all accumulators and counters are 0, and the FSM is in CAL.
- **Outputs before RUN:** `volt`/`sign` hold 0 until the first RUN update.

## Timing
- First `ad_clk` rising edge: first `sys_clk` edge after `sys_rst` deasserts.
- Calibration time: 2^CAL_SHIFT × 2 cycles.
- Divider time: each division takes 27 cycles plus 1 load cycle; a skipped division takes 1 cycle.
- `cal_done` rises at most 2^(CAL_SHIFT+1) + 58 cycles after reset release. Once high, it stays high until the next reset.
- RUN pipeline:
  - Cycle of the last sample capture of a block: the accumulator closes.
  - +1: `avg` is registered.
  - +2: `volt`/`sign` are registered and `volt_vld` is high for exactly that cycle.
- Update rate: one `volt_vld` per 2^(AVG_SHIFT+1) cycles (16 at defaults).
- Reset asserted mid-operation clears all state immediately, independent of the clock. Calibration restarts from sample 0 after release, with no partial-sum carry-over.

## Test plan
- **Reset and clock:** hold `sys_rst` = 1 → all outputs 0. Release → `ad_clk` period is 2 cycles, and `cal_done` stays 0 for the first 2048 cycles.
- **Nominal calibration:** `ad_data` = 128 constant.
  - `mid` = 128, `step_p` = 645039, `step_n` = 640000.
  - `cal_done` rises ≤ 2106 cycles after release.
  - First `volt_vld` gives `volt` = 0, `sign` = 0.
- **Rails** (after nominal calibration):
  - `ad_data` = 255 → `volt` = 9999, `sign` = 0.
  - `ad_data` = 0 → `volt` = 10000, `sign` = 1.
  - `ad_data` = 64 → `volt` = 5000, `sign` = 1.
- **Averaging:** after nominal calibration, drive a block of 4 × 120 then 4 × 136 → `avg` = 128, `volt` = 0, `sign` = 0. `volt_vld` pulses exactly every 16 cycles.
- **Zero-divisor edge:** calibrate with `ad_data` = 0.
  - Result: `mid` = 0, `step_n` = 0, `step_p` = 321254.
  - `ad_data` = 0 → `volt` = 0, `sign` = 0.
  - `ad_data` = 255 → `volt` = 9999, `sign` = 0.
- **Reset mid-calibration:**
  - Pulse `sys_rst` after 500 samples → outputs 0 at once.
  - Then drive `ad_data` = 200 → `mid` = 200, proving the full 1024-sample restart.
  - Then `ad_data` = 255 → `volt` = 9999, `sign` = 0.

Source files
------------

// File: rtl/adc_volt_meas_if.sv
// adc_volt_meas_if
// Groups the ADC-side and display-side signals of the voltmeter front end.
//   ad_data  : 8-bit ADC code, valid while ad_clk is high
//   ad_clk   : ADC sample clock (sys_clk/2)
//   volt     : unsigned magnitude in mV
//   sign     : 1 = negative
//   volt_vld : one-cycle pulse when volt/sign update
//   cal_done : zero-point calibration and step computation finished
// master = measurement block, slave = ADC/display side.
interface adc_volt_meas_if;
   logic [7:0]  ad_data;
   logic        ad_clk;
   logic [15:0] volt;
   logic        sign;
   logic        volt_vld;
   logic        cal_done;

   modport master (
      input  ad_data,
      output ad_clk, volt, sign, volt_vld, cal_done
   );

   modport slave (
      output ad_data,
      input  ad_clk, volt, sign, volt_vld, cal_done
   );
endinterface

// File: rtl/adc_volt_meas.sv
// adc_volt_meas
// ADC front end and voltage computation for the digital voltmeter.
// Generates the ADC sample clock, self-calibrates the zero point (mid) from
// the first 2^CAL_SHIFT samples, derives per-code mV steps for both polarities
// with a sequential restoring divider, then block-averages 2^AVG_SHIFT samples
// and converts each block to a signed millivolt magnitude.
// Ports:
//   sys_clk : system clock
//   sys_rst : asynchronous active-high reset
//   bus     : adc_volt_meas_if.master (ad_data in; ad_clk, volt, sign,
//             volt_vld, cal_done out)
module adc_volt_meas #(
   parameter int unsigned CAL_SHIFT = 10,
   parameter int unsigned AVG_SHIFT = 3,
   parameter int unsigned FS_MV     = 10000
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   adc_volt_meas_if.master  bus
);

   localparam int unsigned CAL_W = 8 + CAL_SHIFT;
   localparam int unsigned AVG_W = 8 + AVG_SHIFT;
   localparam int unsigned FRAC  = 13;
   localparam logic [26:0] NUM   = 27'(FS_MV << FRAC);

   typedef enum logic [1:0] {CAL, DIV_P, DIV_N, RUN} state_t;
   state_t state, state_nx;

   logic                 ad_clk_q;
   logic [CAL_W-1:0]     cal_sum, cal_total;
   logic [CAL_SHIFT-1:0] cal_cnt;
   logic [7:0]           mid;
   logic [26:0]          step_p, step_n;
   logic                 div_busy;
   logic [7:0]           div_rem, rem_nx;
   logic [26:0]          div_quo, quo_nx;
   logic [4:0]           div_cnt;
   logic [7:0]           divisor;
   logic [8:0]           shifted;
   logic                 q_bit, div_zero, div_last, sample, cal_last;
   logic [AVG_W-1:0]     avg_sum, avg_total;
   logic [AVG_SHIFT-1:0] avg_cnt;
   logic [7:0]           avg, diff;
   logic                 avg_vld;
   logic [26:0]          step_sel;
   logic [34:0]          prod;
   logic [21:0]          scaled;
   logic [15:0]          volt_c, volt_q;
   logic                 sign_c, sign_q, volt_vld_q, cal_done_q;

   assign bus.ad_clk   = ad_clk_q;
   assign bus.volt     = volt_q;
   assign bus.sign     = sign_q;
   assign bus.volt_vld = volt_vld_q;
   assign bus.cal_done = cal_done_q;

   // registered ad_clk high means ad_data is valid at this edge
   assign sample    = ad_clk_q;
   assign cal_total = cal_sum + CAL_W'(bus.ad_data);
   assign avg_total = avg_sum + AVG_W'(bus.ad_data);

   always_comb begin
      divisor  = (state == DIV_P) ? (8'hFF - mid) : mid;
      div_zero = (divisor == 8'd0);
      div_last = div_busy && (div_cnt == 5'd26);
      cal_last = (state == CAL) && sample && (&cal_cnt);
      // restoring division step: shift in the next numerator bit, subtract if it fits
      shifted  = {div_rem, div_quo[26]};
      q_bit    = (shifted >= {1'b0, divisor});
      rem_nx   = q_bit ? 8'(shifted - {1'b0, divisor}) : shifted[7:0];
      quo_nx   = {div_quo[25:0], q_bit};
   end

   always_comb begin
      state_nx = state;
      case (state)
         CAL:   if (cal_last) state_nx = DIV_P;
         DIV_P: if ((!div_busy && div_zero) || div_last) state_nx = DIV_N;
         DIV_N: if ((!div_busy && div_zero) || div_last) state_nx = RUN;
         RUN:   state_nx = RUN;
         default: state_nx = CAL;
      endcase
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) state <= CAL;
      else         state <= state_nx;
   end

   always_comb begin
      if (avg >= mid) begin
         diff     = avg - mid;
         step_sel = step_p;
         sign_c   = 1'b0;
      end else begin
         diff     = mid - avg;
         step_sel = step_n;
         sign_c   = 1'b1;
      end
      prod   = {27'd0, diff} * {8'd0, step_sel};
      scaled = 22'(prod >> FRAC);
      volt_c = (scaled > 22'(FS_MV)) ? 16'(FS_MV) : scaled[15:0];
      if (volt_c == 16'd0) sign_c = 1'b0;
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         ad_clk_q   <= 1'b0;
         cal_sum    <= '0;
         cal_cnt    <= '0;
         mid        <= '0;
         step_p     <= '0;
         step_n     <= '0;
         div_busy   <= 1'b0;
         div_rem    <= '0;
         div_quo    <= '0;
         div_cnt    <= '0;
         avg_sum    <= '0;
         avg_cnt    <= '0;
         avg        <= '0;
         avg_vld    <= 1'b0;
         volt_q     <= '0;
         sign_q     <= 1'b0;
         volt_vld_q <= 1'b0;
         cal_done_q <= 1'b0;
      end else begin
         ad_clk_q   <= ~ad_clk_q;
         avg_vld    <= 1'b0;
         volt_vld_q <= 1'b0;
         case (state)
            CAL: if (sample) begin
               cal_cnt <= cal_cnt + 1'b1;
               if (&cal_cnt) begin
                  mid     <= cal_total[CAL_W-1:CAL_SHIFT];
                  cal_sum <= '0;
               end else begin
                  cal_sum <= cal_total;
               end
            end
            DIV_P, DIV_N: begin
               if (!div_busy) begin
                  if (div_zero) begin
                     if (state == DIV_P) step_p <= '0;
                     else begin
                        step_n     <= '0;
                        cal_done_q <= 1'b1;
                     end
                  end else begin
                     div_busy <= 1'b1;
                     div_rem  <= '0;
                     div_quo  <= NUM;
                     div_cnt  <= '0;
                  end
               end else begin
                  div_rem <= rem_nx;
                  div_quo <= quo_nx;
                  div_cnt <= div_cnt + 1'b1;
                  if (div_last) begin
                     div_busy <= 1'b0;
                     if (state == DIV_P) step_p <= quo_nx;
                     else begin
                        step_n     <= quo_nx;
                        cal_done_q <= 1'b1;
                     end
                  end
               end
            end
            RUN: begin
               if (sample) begin
                  avg_cnt <= avg_cnt + 1'b1;
                  if (&avg_cnt) begin
                     avg     <= avg_total[AVG_W-1:AVG_SHIFT];
                     avg_sum <= '0;
                     avg_vld <= 1'b1;
                  end else begin
                     avg_sum <= avg_total;
                  end
               end
               if (avg_vld) begin
                  volt_q     <= volt_c;
                  sign_q     <= sign_c;
                  volt_vld_q <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
